// File: rtl/data_mem_responder.sv
// Word-addressed data memory for the core's MEM stage, one request outstanding at a time.
// Latency: response pulse LATENCY cycles after the accept edge; next accept one cycle after the response.
// Backpressure: req_ready is low from acceptance through the response cycle; the core must hold its request.
module data_mem_responder #(
   parameter int NUM_WORDS = 16384,
   parameter int LATENCY   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        busy
);

   localparam int         IDX_W  = $clog2(NUM_WORDS);
   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;

   logic               write_q;
   logic [IDX_W-1:0]   idx_q;
   logic [31:0]        wdata_q;
   logic [31:0]        rdata_q;

   logic [31:0]        mem_q [NUM_WORDS];

   logic               accept;
   logic               commit;
   logic               cmt_write;
   logic [IDX_W-1:0]   cmt_idx;
   logic [31:0]        cmt_wdata;

   // Byte offset and bits above the array size do not select a word; addresses simply wrap.
   logic               unused_addr_bits;
   assign unused_addr_bits = ^{req_addr[31:IDX_W+2], req_addr[1:0]};

   assign accept = (state_q == ST_IDLE) && req_valid;

   // The array access happens on the edge that enters RESP. With LATENCY==1 that is the accept
   // edge itself, so the access uses the live request instead of the captured copy.
   always_comb begin
      commit    = 1'b0;
      cmt_write = write_q;
      cmt_idx   = idx_q;
      cmt_wdata = wdata_q;
      if (state_q == ST_IDLE) begin
         commit    = accept && (LATENCY == 1);
         cmt_write = req_write;
         cmt_idx   = req_addr[IDX_W+1:2];
         cmt_wdata = req_wdata;
      end else if (state_q == ST_WAIT) begin
         commit = (cnt_q <= 8'd1);
      end
   end

   // State and latency counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: counter is loaded on accept and WAIT ends once it has counted down to 1.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               cnt_d   = LAT_M1;
               state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
            if (cnt_q <= 8'd1) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   // Handshake outputs decode straight from state so reset reaches them without a clock.
   always_comb begin
      req_ready  = (state_q == ST_IDLE);
      resp_valid = (state_q == ST_RESP);
      busy       = (state_q != ST_IDLE);
   end

   assign resp_rdata = rdata_q;

   // Request capture on accept; load data (zero for a store ack) registered on the commit edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         write_q <= 1'b0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         if (accept) begin
            write_q <= req_write;
            idx_q   <= req_addr[IDX_W+1:2];
            wdata_q <= req_wdata;
         end
         if (commit) begin
            rdata_q <= cmt_write ? 32'd0 : mem_q[cmt_idx];
         end
      end
   end

   // Storage array: cleared by reset, written only on a store's commit edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            mem_q[IDX_W'(i)] <= 32'd0;
         end
      end else if (commit && cmt_write) begin
         mem_q[cmt_idx] <= cmt_wdata;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   // Instance A: default array, LATENCY=4
   logic        rst_a;
   logic        a_valid, a_ready, a_write, a_resp_valid, a_busy;
   logic [31:0] a_addr, a_wdata, a_rdata;
   // Instance B: 16 words, LATENCY=1
   logic        rst_b;
   logic        b_valid, b_ready, b_write, b_resp_valid, b_busy;
   logic [31:0] b_addr, b_wdata, b_rdata;

   data_mem_responder #(.NUM_WORDS(16384), .LATENCY(4)) u_dut_a (
      .clk        (clk),
      .reset      (rst_a),
      .req_valid  (a_valid),
      .req_ready  (a_ready),
      .req_write  (a_write),
      .req_addr   (a_addr),
      .req_wdata  (a_wdata),
      .resp_valid (a_resp_valid),
      .resp_rdata (a_rdata),
      .busy       (a_busy)
   );

   data_mem_responder #(.NUM_WORDS(16), .LATENCY(1)) u_dut_b (
      .clk        (clk),
      .reset      (rst_b),
      .req_valid  (b_valid),
      .req_ready  (b_ready),
      .req_write  (b_write),
      .req_addr   (b_addr),
      .req_wdata  (b_wdata),
      .resp_valid (b_resp_valid),
      .resp_rdata (b_rdata),
      .busy       (b_busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic get_ready(input bit b);
      return b ? b_ready : a_ready;
   endfunction
   function automatic logic get_valid(input bit b);
      return b ? b_valid : a_valid;
   endfunction
   function automatic logic get_resp(input bit b);
      return b ? b_resp_valid : a_resp_valid;
   endfunction
   function automatic logic get_busy(input bit b);
      return b ? b_busy : a_busy;
   endfunction
   function automatic logic [31:0] get_rdata(input bit b);
      return b ? b_rdata : a_rdata;
   endfunction

   task automatic drive(input bit b, input logic v, input logic w, input logic [31:0] ad, input logic [31:0] wd);
      if (b) begin
         b_valid = v; b_write = w; b_addr = ad; b_wdata = wd;
      end else begin
         a_valid = v; a_write = w; a_addr = ad; a_wdata = wd;
      end
   endtask

   // Called at a negedge; returns the index of the accepting posedge, just after it.
   task automatic wait_accept(input bit b, output int e);
      e = -1;
      for (int i = 0; i < 50; i++) begin
         if (get_ready(b) && get_valid(b)) begin
            e = cyc + 1;
            break;
         end
         @(negedge clk);
      end
      if (e < 0) check_eq("accept_timeout", 32'(get_ready(b)), 32'd1);
      else @(posedge clk);
   endtask

   // Called at the negedge after acceptance edge e (cycle 1); rel is the cycle holding resp_valid.
   task automatic wait_resp(input bit b, input int e, output int rel, output logic [31:0] rd, output int busy_low);
      rel = -1;
      rd = 32'hxxxx_xxxx;
      busy_low = 0;
      for (int i = 0; i < 300; i++) begin
         if (!get_busy(b)) busy_low++;
         if (get_resp(b)) begin
            rel = cyc - e + 1;
            rd = get_rdata(b);
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic xact(input bit b, input string tag, input logic w, input logic [31:0] ad,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input int lat, output int e);
      int rel, bl;
      logic [31:0] rd;
      drive(b, 1'b1, w, ad, wd);
      wait_accept(b, e);
      @(negedge clk);
      drive(b, 1'b0, 1'b0, 32'd0, 32'd0);
      wait_resp(b, e, rel, rd, bl);
      check_eq({tag, "_lat"}, 32'(rel), 32'(lat));
      check_eq({tag, "_data"}, rd, exp_rd);
      check_eq({tag, "_busy_low"}, 32'(bl), 32'd0);
      @(negedge clk);
      check_eq({tag, "_resp_once"}, 32'(get_resp(b)), 32'd0);
      check_eq({tag, "_idle_busy"}, 32'(get_busy(b)), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      int e, e0, e1, rel, bl, pulses;
      logic [31:0] rd;
      logic        b2b_w   [5];
      logic [31:0] b2b_ad  [5];
      logic [31:0] b2b_wd  [5];
      logic [31:0] b2b_exp [5];

      b2b_w[0] = 1'b1; b2b_ad[0] = 32'h4;  b2b_wd[0] = 32'hA5A5A5A5; b2b_exp[0] = 32'h0;
      b2b_w[1] = 1'b0; b2b_ad[1] = 32'h44; b2b_wd[1] = 32'h0;        b2b_exp[1] = 32'hA5A5A5A5;
      b2b_w[2] = 1'b1; b2b_ad[2] = 32'h8;  b2b_wd[2] = 32'h0BADF00D; b2b_exp[2] = 32'h0;
      b2b_w[3] = 1'b0; b2b_ad[3] = 32'h8;  b2b_wd[3] = 32'h0;        b2b_exp[3] = 32'h0BADF00D;
      b2b_w[4] = 1'b0; b2b_ad[4] = 32'h4;  b2b_wd[4] = 32'h0;        b2b_exp[4] = 32'hA5A5A5A5;

      rst_a = 1'b0;
      rst_b = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      rst_b = 1'b1;
      #1;
      check_eq("rst_ready", 32'(a_ready), 32'd1);
      check_eq("rst_resp_valid", 32'(a_resp_valid), 32'd0);
      check_eq("rst_busy", 32'(a_busy), 32'd0);
      check_eq("rst_rdata", a_rdata, 32'd0);
      check_eq("rst_b_ready", 32'(b_ready), 32'd1);
      @(negedge clk);

      // Fresh array reads zero
      xact(1'b0, "ld_reset", 1'b0, 32'h100, 32'd0, 32'd0, 4, e);

      // Store then load, minimum spacing LATENCY+1
      xact(1'b0, "st_beef", 1'b1, 32'h40, 32'hDEADBEEF, 32'd0, 4, e0);
      xact(1'b0, "ld_beef", 1'b0, 32'h40, 32'd0, 32'hDEADBEEF, 4, e1);
      check_eq("ld_beef_spacing", 32'(e1 - e0), 32'd5);

      // Inputs changing while busy are ignored; held request accepted right after RESP
      drive(1'b0, 1'b1, 1'b1, 32'h200, 32'h11111111);
      wait_accept(1'b0, e0);
      @(negedge clk);
      rel = -1;
      for (int i = 0; i < 20; i++) begin
         if (a_resp_valid) begin
            rel = cyc - e0 + 1;
            break;
         end
         if (i % 2 == 1) drive(1'b0, 1'b1, 1'b1, 32'h20C, 32'h44444444);
         else            drive(1'b0, 1'b1, 1'b1, 32'h208, 32'h33333333);
         @(negedge clk);
      end
      check_eq("hold_lat", 32'(rel), 32'd4);
      check_eq("hold_st_ack_data", a_rdata, 32'd0);
      drive(1'b0, 1'b1, 1'b1, 32'h204, 32'h22222222);
      wait_accept(1'b0, e1);
      check_eq("hold_next_accept", 32'(e1 - e0), 32'd5);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      wait_resp(1'b0, e1, rel, rd, bl);
      check_eq("hold2_lat", 32'(rel), 32'd4);
      @(negedge clk);
      xact(1'b0, "ld_200", 1'b0, 32'h200, 32'd0, 32'h11111111, 4, e);
      xact(1'b0, "ld_204", 1'b0, 32'h204, 32'd0, 32'h22222222, 4, e);
      xact(1'b0, "ld_208", 1'b0, 32'h208, 32'd0, 32'd0, 4, e);
      xact(1'b0, "ld_20c", 1'b0, 32'h20C, 32'd0, 32'd0, 4, e);

      // Aliasing on the 16-word instance: 0x43 and 0x00 hit word 0
      xact(1'b1, "st_alias", 1'b1, 32'h43, 32'h12345678, 32'd0, 1, e);
      xact(1'b1, "ld_alias", 1'b0, 32'h00, 32'd0, 32'h12345678, 1, e);

      // LATENCY=1 back-to-back with valid held high
      drive(1'b1, 1'b1, b2b_w[0], b2b_ad[0], b2b_wd[0]);
      e0 = -1;
      for (int k = 0; k < 5; k++) begin
         wait_accept(1'b1, e);
         if (k > 0) check_eq("b2b_spacing", 32'(e - e0), 32'd2);
         e0 = e;
         @(negedge clk);
         if (k < 4) drive(1'b1, 1'b1, b2b_w[k+1], b2b_ad[k+1], b2b_wd[k+1]);
         else       drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
         check_eq("b2b_resp", 32'(b_resp_valid), 32'd1);
         check_eq("b2b_data", b_rdata, b2b_exp[k]);
         @(negedge clk);
         check_eq("b2b_gap", 32'(b_resp_valid), 32'd0);
      end

      // Reset in the middle of a store: dropped, nothing committed, no response
      drive(1'b0, 1'b1, 1'b1, 32'h8, 32'hAAAA5555);
      wait_accept(1'b0, e);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      check_eq("mid_busy_before_rst", 32'(a_busy), 32'd1);
      #2 rst_a = 1'b0;
      #1;
      check_eq("async_rst_ready", 32'(a_ready), 32'd1);
      check_eq("async_rst_busy", 32'(a_busy), 32'd0);
      pulses = 0;
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      repeat (8) begin
         if (a_resp_valid) pulses++;
         @(negedge clk);
      end
      check_eq("mid_rst_no_resp", 32'(pulses), 32'd0);
      xact(1'b0, "ld_after_rst", 1'b0, 32'h8, 32'd0, 32'd0, 4, e);
      xact(1'b0, "ld_40_cleared", 1'b0, 32'h40, 32'd0, 32'd0, 4, e);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder for the pipelined RISC-V core. It serves word loads and stores from the core's MEM stage over a valid/ready request channel and a one-cycle response pulse. It models a memory with a fixed, parameterised access latency, so the core's stall logic can be exercised against a non-ideal memory. One request is outstanding at a time; requests are neither queued nor reordered.

## Interface
- NUM_WORDS, 16384: number of 32-bit words in the array. Power of two.
- LATENCY, 4: cycles from request acceptance to response. Legal range 1..255.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  core presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load. Sampled on acceptance.
- req_addr  input  32  byte address. Sampled on acceptance.
- req_wdata  input  32  store data. Sampled on acceptance.
- resp_valid  output  1  one-cycle pulse: the request has completed.
- resp_rdata  output  32  load data. Valid while resp_valid is high.
- busy  output  1  a request has been accepted and is not yet completed. Used by the core's hazard/stall logic.

## Operation
- Word index is req_addr[log2(NUM_WORDS)+1:2].
  - req_addr[1:0] is ignored; there is no misalignment fault.
  - Upper address bits are ignored, so addresses wrap modulo NUM_WORDS*4.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid=1, capture write, index and wdata, and load the down-counter with LATENCY-1.
  - If LATENCY==1, go directly to RESP. Otherwise go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to RESP on the next edge.
  - Stores commit to the array on the WAIT->RESP (or IDLE->RESP) edge.
  - Loads register resp_rdata from the array on that same edge.
- RESP:
  - resp_valid=1 for exactly one cycle, then return to IDLE.
  - req_ready=0 in RESP, so no request is accepted in the response cycle.
- Stores also produce a resp_valid pulse as an acknowledge. resp_rdata is 0 for stores.
- Inputs presented while req_ready=0 are ignored; the core must hold them.

## Timing
- Reset values:
  - State IDLE.
  - req_ready=1, resp_valid=0, busy=0, resp_rdata=0, counter=0.
  - All array words are 0.
- Reset is asynchronous: outputs reach their reset values immediately on reset falling, independent of clk.
- Acceptance occurs at rising edge E (req_valid & req_ready). resp_valid is then high in the cycle after edge E+LATENCY-1, i.e. LATENCY cycles after the accept edge.
- busy:
  - high from the cycle after acceptance through the RESP cycle inclusive;
  - equals ~req_ready.
- Minimum request-to-request spacing is LATENCY+1 cycles: the next accept is at the edge after the RESP cycle.
- A load issued after a store's response returns the stored value; there is no stale read.
- Reset asserted mid-request: the request is dropped, no store commits, and no response is issued.

## Test plan
- Reset: hold reset=0 for 2 cycles, then release.
  - Expect req_ready=1, resp_valid=0, busy=0 after release.
  - Load from 0x100 returns 0.
- Store/load with LATENCY=4:
  - Store 0xDEADBEEF to 0x40, accepted at edge 0. resp_valid pulses in cycle 4; busy is high in cycles 1-4.
  - Load from 0x40 accepted at edge 5. resp_valid in cycle 9 with resp_rdata=0xDEADBEEF.
- Ignored inputs:
  - Hold req_valid=1 with changing address while busy=1.
  - Only the first address is serviced.
  - The next accept occurs exactly at the edge after RESP.
- Address aliasing with NUM_WORDS=16:
  - Store 0x12345678 to 0x43, then load 0x00 (wraps to word 0 and ignores low bits).
  - The load returns 0x12345678.
- LATENCY=1:
  - Back-to-back requests held valid.
  - resp_valid pulses every 2 cycles, and each pulse carries the correct data.
- Reset mid-store:
  - Store 0xAAAA5555 to 0x8, then pull reset low 2 cycles after acceptance (LATENCY=4).
  - No resp_valid is issued, and a subsequent load of 0x8 returns 0.
